// File: rtl/bsg_thermometer_credit_ctrl.sv
// bsg_thermometer_credit_ctrl
//   Credit controller for a shared pool of up to width_p credits. The credit
//   state lives in a thermometer-coded register (ones packed at the LSB). The
//   count is decoded combinationally from that register.
//   A producer takes one credit per accepted transfer (v_i & ready_o). A
//   downstream sink returns 0..max_ret_p credits per cycle. A drain sequence
//   blocks issue until the pool is full again and then pulses drain_done_o.
//
// Ports
//   clk_i, reset_i  clock; synchronous active-high reset
//   v_i             producer requests one credit
//   ready_o         credit available and FSM in RUN
//   ret_count_i     credits returned this cycle (0 = none)
//   drain_i         start a drain (only looked at in RUN)
//   drain_done_o    one-cycle pulse in the DONE state
//   credits_o       current credit count
//   empty_o         no credits left
//   full_o          pool completely full
//   overflow_o      sticky: a return tried to push the count past width_p
//   state_o         FSM state for debug (0 RUN, 1 DRAIN, 2 DONE)
//
// Handshake: a credit is consumed in every cycle where v_i and ready_o are both
// high at the clock edge. ready_o depends only on registered state. A producer
// may hold v_i high while ready_o is low; nothing is consumed in that case.

module bsg_thermometer_credit_ctrl #(
  parameter int width_p        = 16,
  parameter int init_credits_p = 16,
  parameter int max_ret_p      = 4
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic                               v_i,
  output logic                               ready_o,
  input  logic [$clog2(max_ret_p+1)-1:0]     ret_count_i,
  input  logic                               drain_i,
  output logic                               drain_done_o,
  output logic [$clog2(width_p+1)-1:0]       credits_o,
  output logic                               empty_o,
  output logic                               full_o,
  output logic                               overflow_o,
  output logic [1:0]                         state_o
);

  localparam int CW = $clog2(width_p+1);
  localparam int NW = CW + 1;              // one spare bit so overflow is visible
  localparam int RW = $clog2(max_ret_p+1);
  localparam logic [RW-1:0] MAX_RET = RW'(max_ret_p);
  localparam logic [NW-1:0] WIDTH_N = NW'(width_p);
  localparam logic [NW-1:0] INIT_N  = NW'(init_credits_p);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Build a thermometer code with n ones at the LSB.
  function automatic logic [width_p-1:0] therm_of(input logic [NW-1:0] n);
    logic [width_p-1:0] t;
    for (int i = 0; i < width_p; i++) begin
      t[i] = (NW'(i) < n);
    end
    return t;
  endfunction

  // Count the ones in a thermometer code.
  function automatic logic [CW-1:0] therm_count(input logic [width_p-1:0] t);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < width_p; i++) begin
      c = c + CW'(t[i]);
    end
    return c;
  endfunction

  logic [width_p-1:0] therm_q, therm_d;
  logic               overflow_q, overflow_d;
  state_e             state_q, state_d;

  logic [RW-1:0]      ret_eff;
  logic               consume;
  logic [NW-1:0]      next_cnt;
  logic               overflow_now;

  // Registered-state outputs only; none of these see v_i, ret_count_i or drain_i.
  assign credits_o    = therm_count(therm_q);
  assign empty_o      = ~therm_q[0];
  assign full_o       = therm_q[width_p-1];
  assign ready_o      = therm_q[0] & (state_q == RUN);
  assign drain_done_o = (state_q == DONE);
  assign overflow_o   = overflow_q;
  assign state_o      = state_q;

  // Credit update. Consume and return net out in the same cycle; a count that
  // would exceed the pool saturates at full and trips the sticky error.
  always_comb begin
    ret_eff      = (ret_count_i > MAX_RET) ? MAX_RET : ret_count_i;
    consume      = v_i & ready_o;
    next_cnt     = NW'(credits_o) + NW'(ret_eff) - NW'(consume);
    overflow_now = (next_cnt > WIDTH_N);
    therm_d      = overflow_now ? '1 : therm_of(next_cnt);
    overflow_d   = overflow_q | overflow_now;
  end

  // Drain FSM. DRAIN leaves once the pool is full; DONE lasts one cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (drain_i) state_d = DRAIN;
      DRAIN:   if (full_o)  state_d = DONE;
      DONE:    state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      therm_q    <= therm_of(INIT_N);
      overflow_q <= 1'b0;
      state_q    <= RUN;
    end else begin
      therm_q    <= therm_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
    end
  end

  // Returning more than max_ret_p in one cycle is an upstream bug; the logic
  // above clamps it so the pool stays consistent.
  ret_in_range_a: assert property (@(posedge clk_i) disable iff (reset_i)
                                   ret_count_i <= MAX_RET);

endmodule

// File: tb/tb_bsg_thermometer_credit_ctrl.sv
// Directed bench for bsg_thermometer_credit_ctrl (width 16, init 16, max return 4).
// Inputs change 1 ns after a rising edge. Outputs are checked at that same
// point, so each check sees the register state left by the edge just taken.

module tb_bsg_thermometer_credit_ctrl;

  localparam int W  = 16;
  localparam int CW = $clog2(W+1);
  localparam int RW = $clog2(4+1);

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          v_i;
  logic          ready_o;
  logic [RW-1:0] ret_count_i;
  logic          drain_i;
  logic          drain_done_o;
  logic [CW-1:0] credits_o;
  logic          empty_o;
  logic          full_o;
  logic          overflow_o;
  logic [1:0]    state_o;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  bsg_thermometer_credit_ctrl #(
    .width_p(16), .init_credits_p(16), .max_ret_p(4)
  ) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .v_i          (v_i),
    .ready_o      (ready_o),
    .ret_count_i  (ret_count_i),
    .drain_i      (drain_i),
    .drain_done_o (drain_done_o),
    .credits_o    (credits_o),
    .empty_o      (empty_o),
    .full_o       (full_o),
    .overflow_o   (overflow_o),
    .state_o      (state_o)
  );

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_credits(input string name, input int exp);
    n_checks++;
    if (credits_o !== CW'(exp)) begin
      n_fail++;
      $display("FAIL %s: credits_o=%0d expected %0d", name, credits_o, exp);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_i = 1'b1; v_i = 1'b0; ret_count_i = '0; drain_i = 1'b0;
    step(); step();
    reset_i = 1'b0;
    chk_credits("reset_credits", 16);
    n_checks++;
    if ({full_o, ready_o, empty_o, overflow_o, drain_done_o} !== 5'b11000) begin
      n_fail++;
      $display("FAIL reset_flags: full/ready/empty/ovf/done=%b expected 11000",
               {full_o, ready_o, empty_o, overflow_o, drain_done_o});
    end
    n_checks++;
    if (state_o !== S_RUN) begin
      n_fail++;
      $display("FAIL reset_state: state_o=%0d expected %0d", state_o, S_RUN);
    end
  endtask

  task automatic test_consume();
    v_i = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      chk_credits("consume_count", 16 - k);
      n_checks++;
      if (ready_o !== (k < 16) || empty_o !== (k == 16)) begin
        n_fail++;
        $display("FAIL consume_flags k=%0d: ready_o=%b empty_o=%b expected %b %b",
                 k, ready_o, empty_o, (k < 16), (k == 16));
      end
    end
    for (int k = 0; k < 3; k++) begin
      step();
      chk_credits("consume_at_empty", 0);
    end
    v_i = 1'b0;
  endtask

  task automatic test_net_update();
    ret_count_i = 3'd4; step(); chk_credits("ret4_from_0", 4);
    n_checks++;
    if (ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_return: ready_o=%b expected 1", ready_o);
    end
    ret_count_i = 3'd1; step(); chk_credits("ret1", 5);
    v_i = 1'b1; ret_count_i = 3'd3; step(); chk_credits("net_v1_r3", 7);
    ret_count_i = 3'd0; step(); chk_credits("v1_r0", 6);
    v_i = 1'b0;
  endtask

  task automatic test_overflow();
    ret_count_i = 3'd4; step(); chk_credits("fill_10", 10);
    step(); chk_credits("fill_14", 14);
    n_checks++;
    if (overflow_o !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_before: overflow_o=%b expected 0", overflow_o);
    end
    step();
    chk_credits("ovf_saturate", 16);
    n_checks++;
    if (overflow_o !== 1'b1 || full_o !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_set: overflow_o=%b full_o=%b expected 1 1", overflow_o, full_o);
    end
    ret_count_i = 3'd0;
    for (int k = 0; k < 20; k++) begin
      step();
      n_checks++;
      if (overflow_o !== 1'b1) begin
        n_fail++;
        $display("FAIL ovf_sticky k=%0d: overflow_o=%b expected 1", k, overflow_o);
      end
    end
    reset_i = 1'b1; step(); reset_i = 1'b0;
    n_checks++;
    if (overflow_o !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_cleared: overflow_o=%b expected 0", overflow_o);
    end
    chk_credits("ovf_reset_credits", 16);
  endtask

  task automatic test_drain();
    v_i = 1'b1;
    for (int k = 0; k < 6; k++) step();
    chk_credits("drain_pre", 10);
    drain_i = 1'b1; step(); drain_i = 1'b0;
    chk_credits("drain_entry_consume", 9);
    n_checks++;
    if (state_o !== S_DRAIN || ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_entry: state_o=%0d ready_o=%b expected %0d 0", state_o, ready_o, S_DRAIN);
    end
    // v_i stays high: must be blocked while draining
    ret_count_i = 3'd3; step(); chk_credits("drain_ret3", 12);
    ret_count_i = 3'd2; step(); chk_credits("drain_ret2a", 14);
    ret_count_i = 3'd2; step(); chk_credits("drain_ret2b", 16);
    n_checks++;
    if (state_o !== S_DRAIN || drain_done_o !== 1'b0 || ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_full_cycle: state_o=%0d done=%b ready=%b expected %0d 0 0",
               state_o, drain_done_o, ready_o, S_DRAIN);
    end
    ret_count_i = 3'd0; step();
    n_checks++;
    if (state_o !== S_DONE || drain_done_o !== 1'b1 || ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_done: state_o=%0d done=%b ready=%b expected %0d 1 0",
               state_o, drain_done_o, ready_o, S_DONE);
    end
    chk_credits("drain_done_credits", 16);
    v_i = 1'b0;
    step();
    n_checks++;
    if (state_o !== S_RUN || drain_done_o !== 1'b0 || ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_exit: state_o=%0d done=%b ready=%b expected %0d 0 1",
               state_o, drain_done_o, ready_o, S_RUN);
    end
    chk_credits("drain_exit_credits", 16);
  endtask

  task automatic test_drain_already_full();
    drain_i = 1'b1; step(); drain_i = 1'b0;
    n_checks++;
    if (state_o !== S_DRAIN) begin
      n_fail++;
      $display("FAIL full_drain_enter: state_o=%0d expected %0d", state_o, S_DRAIN);
    end
    step();
    n_checks++;
    if (state_o !== S_DONE || drain_done_o !== 1'b1) begin
      n_fail++;
      $display("FAIL full_drain_done: state_o=%0d done=%b expected %0d 1", state_o, drain_done_o, S_DONE);
    end
    step();
    n_checks++;
    if (state_o !== S_RUN || drain_done_o !== 1'b0) begin
      n_fail++;
      $display("FAIL full_drain_exit: state_o=%0d done=%b expected %0d 0", state_o, drain_done_o, S_RUN);
    end
  endtask

  task automatic test_reset_in_drain();
    v_i = 1'b1;
    for (int k = 0; k < 12; k++) step();
    v_i = 1'b0;
    chk_credits("rid_pre", 4);
    drain_i = 1'b1; step(); drain_i = 1'b0;
    step();
    n_checks++;
    if (state_o !== S_DRAIN) begin
      n_fail++;
      $display("FAIL rid_draining: state_o=%0d expected %0d", state_o, S_DRAIN);
    end
    reset_i = 1'b1; ret_count_i = 3'd2; v_i = 1'b1;
    step();
    reset_i = 1'b0; ret_count_i = 3'd0; v_i = 1'b0;
    n_checks++;
    if (state_o !== S_RUN || drain_done_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rid_after_reset: state_o=%0d done=%b expected %0d 0", state_o, drain_done_o, S_RUN);
    end
    chk_credits("rid_credits", 16);
    for (int k = 0; k < 5; k++) begin
      step();
      n_checks++;
      if (drain_done_o !== 1'b0 || state_o !== S_RUN) begin
        n_fail++;
        $display("FAIL rid_no_pulse k=%0d: done=%b state_o=%0d expected 0 %0d",
                 k, drain_done_o, state_o, S_RUN);
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_consume();
    test_net_update();
    test_overflow();
    test_drain();
    test_drain_already_full();
    test_reset_in_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
